// File: rtl/simon_sequence_player.sv
// Simon-style game engine: each round appends one random colour, replays the whole
// sequence on the lamp outputs, then checks the player's button presses against it.
module simon_sequence_player #(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 50,
  parameter int GAP_CYCLES     = 25,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   rnd,
  input  logic [3:0]                   btn,
  output logic                         show_valid,
  output logic [1:0]                   show_color,
  output logic                         awaiting_input,
  output logic [$clog2(MAX_LEN+1)-1:0] score,
  output logic                         fail,
  output logic                         win
);

  localparam int SW   = $clog2(MAX_LEN + 1);
  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TSG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX = (TSG > TIMEOUT_CYCLES) ? TSG : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADD      = 3'd1;
  localparam logic [2:0] S_SHOW_ON  = 3'd2;
  localparam logic [2:0] S_SHOW_OFF = 3'd3;
  localparam logic [2:0] S_WAIT_IN  = 3'd4;
  localparam logic [2:0] S_FAIL     = 3'd5;
  localparam logic [2:0] S_WIN      = 3'd6;

  logic [2:0]    state;
  logic [1:0]    mem [MAX_LEN];
  logic [SW-1:0] len;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic [3:0]    prev_btn;
  logic [3:0]    press;
  logic [1:0]    cur_color;
  logic          idx_last;
  logic          press_hit;

  assign press     = btn & ~prev_btn;
  assign cur_color = mem[idx];
  assign idx_last  = ((SW'(idx) + SW'(1)) == len);
  // A multi-bit press can never equal the one-hot code, so it fails like a wrong colour.
  assign press_hit = (press == (4'b0001 << cur_color));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      len      <= '0;
      idx      <= '0;
      timer    <= '0;
      score    <= '0;
      prev_btn <= '0;
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= 2'd0;
    end else begin
      prev_btn <= btn;
      case (state)
        S_IDLE, S_FAIL, S_WIN: begin
          if (start) begin
            len   <= '0;
            idx   <= '0;
            timer <= '0;
            score <= '0;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          mem[len[IW-1:0]] <= rnd;
          len   <= len + SW'(1);
          idx   <= '0;
          timer <= '0;
          state <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (timer == TW'(SHOW_CYCLES - 1)) begin
            timer <= '0;
            state <= S_SHOW_OFF;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_SHOW_OFF: begin
          if (timer == TW'(GAP_CYCLES - 1)) begin
            timer <= '0;
            if (idx_last) begin
              idx   <= '0;
              state <= S_WAIT_IN;
            end else begin
              idx   <= idx + IW'(1);
              state <= S_SHOW_ON;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_IN: begin
          // A press on the timeout terminal count is judged as a press.
          if (press != 4'd0) begin
            if (!press_hit) begin
              state <= S_FAIL;
            end else begin
              timer <= '0;
              if (idx_last) begin
                score <= len;
                idx   <= '0;
                state <= (len == SW'(MAX_LEN)) ? S_WIN : S_ADD;
              end else begin
                idx <= idx + IW'(1);
              end
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= S_FAIL;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign show_valid     = (state == S_SHOW_ON);
  assign show_color     = show_valid ? cur_color : 2'd0;
  assign awaiting_input = (state == S_WAIT_IN);
  assign fail           = (state == S_FAIL);
  assign win            = (state == S_WIN);

endmodule
